lockstep_mode_ctrl: RTL and testbench
=====================================

# lockstep_mode_ctrl

Sequencer that owns the `lockstep_mode` and `same_address` controls of the cluster's TCDM lockstep unit. It accepts mode-change requests from the cluster peripheral interconnect and stalls all core request ports. It then drains every outstanding TCDM transaction and switches mode only when the lockstep unit's grant/rvalid counters are guaranteed idle. While lockstep is active it also generates the data-broadcast (`same_address`) indication from the cores' request addresses.

## Interface
- `NB_CORES`, 8, number of core ports supervised
- `ADDR_WIDTH`, 32, TCDM request address width
- `MAX_OUTSTANDING`, 4, max in-flight transactions per core; counter width is `$clog2(MAX_OUTSTANDING+1)`
- `DRAIN_TIMEOUT`, 1024, cycles allowed in DRAIN before abort; 0 disables the timeout; timer is 16 bits
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `cfg_req_i`  in  1  single-cycle mode-change request pulse
- `cfg_mode_i`  in  1  target mode, sampled with `cfg_req_i` (1 = lockstep)
- `cfg_ack_o`  out  1  one-cycle completion pulse
- `cfg_err_o`  out  1  high with `cfg_ack_o` when the drain timed out
- `busy_o`  out  1  high in any state other than RUN
- `core_req_i`  in  NB_CORES  per-core TCDM request, core side
- `core_gnt_i`  in  NB_CORES  per-core grant, core side
- `core_rvalid_i`  in  NB_CORES  per-core response valid, core side
- `core_addr_i`  in  NB_CORES*ADDR_WIDTH  per-core address; core k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- `core_stall_o`  out  NB_CORES  request gate to core k; all bits are equal
- `lockstep_mode_o`  out  1  registered mode to the lockstep unit
- `same_address_o`  out  1  broadcast indication to the lockstep unit

## Operation
- Outstanding counter per core:
  - +1 on `core_req_i & core_gnt_i`.
  - −1 on `core_rvalid_i`.
  - Unchanged when both occur in the same cycle.
  - A decrement at 0 is ignored, and the counter stays at 0.
  - An increment at MAX_OUTSTANDING saturates, and the counter stays at MAX_OUTSTANDING.
- Drained: all counters are 0 and there is no `req&gnt` handshake on any core in the current cycle.
- FSM states: RUN, DRAIN, SWITCH, ABORT.
- RUN:
  - stall=0, busy=0.
  - `cfg_req_i` with `cfg_mode_i != lockstep_mode_o`: latch the target mode and go to DRAIN.
  - `cfg_req_i` with `cfg_mode_i == lockstep_mode_o`: go to SWITCH with no mode change.
- DRAIN:
  - stall=all 1, busy=1. The timer clears on entry and increments every cycle in DRAIN.
  - Drained: load `lockstep_mode_o` ← target and go to SWITCH.
  - Else, when DRAIN_TIMEOUT≠0 and timer == DRAIN_TIMEOUT−1: go to ABORT.
  - Drained takes priority over timeout in the same cycle.
- SWITCH: stall=1, ack=1, err=0 for one cycle, then RUN.
- ABORT:
  - stall=1, ack=1, err=1 for one cycle, then RUN.
  - `lockstep_mode_o` and the counters are unchanged.
- `cfg_req_i` is ignored in every state except RUN; there is no queuing.
- `same_address_o` is combinational. It is 1 only when all of the following hold:
  - `lockstep_mode_o`=1;
  - all `core_req_i` bits are 1;
  - all NB_CORES addresses are bitwise equal.
- `same_address_o` is forced 0 whenever stall=1.
- Outputs `cfg_ack_o`, `cfg_err_o`, `busy_o` and `core_stall_o` are decoded from the registered state only (Moore). They are never derived from inputs.

## Timing
- Reset values: state RUN, `lockstep_mode_o`=0, `core_stall_o`=0, `cfg_ack_o`=0, `cfg_err_o`=0, `busy_o`=0, all counters 0, timer 0.
- Asserting `rst_ni` mid-operation (any state) returns the block to reset values immediately. No ack is produced for the interrupted request.
- Mode change with nothing outstanding, `cfg_req_i` at cycle 0:
  - cycle 1: DRAIN, stall=1;
  - cycle 2: SWITCH, new `lockstep_mode_o`, ack=1;
  - cycle 3: RUN, stall=0.
- Same-mode request at cycle 0: ack at cycle 1, stall=1 for that one cycle, no mode change.
- Stall rises one cycle after acceptance. A handshake in the acceptance cycle is counted and drained normally.
- The last rvalid at cycle N in DRAIN means drained is true at cycle N+1. Then SWITCH is at N+2.
- Timeout with DRAIN_TIMEOUT=T: DRAIN occupies exactly T cycles, and ABORT is the cycle after.
- `lockstep_mode_o` changes only on the DRAIN→SWITCH edge. Stall is high in that cycle and the cycle after it.

## Test plan
- Reset, then `cfg_req_i`=1, `cfg_mode_i`=1 with no traffic:
  - stall high cycles 1–2;
  - `lockstep_mode_o`=1 from cycle 2;
  - `cfg_ack_o` pulse cycle 2, `cfg_err_o`=0;
  - `busy_o` low cycle 3.
- Cores 0 and 5 each have 2 outstanding (granted, no rvalid), then enter-lockstep is requested:
  - stays in DRAIN until the 4th rvalid, at cycle N;
  - SWITCH at N+2, `lockstep_mode_o`=1 at N+2.
- DRAIN_TIMEOUT=16, core 3 with 1 outstanding and never any rvalid:
  - exactly 16 DRAIN cycles;
  - `cfg_ack_o`=`cfg_err_o`=1 for one cycle;
  - `lockstep_mode_o` remains 0, stall released the next cycle.
- In lockstep, all 8 `core_req_i`=1:
  - all addresses 0x1000_0040: `same_address_o`=1;
  - core 7 address changed to 0x1000_0044: `same_address_o`=0;
  - core 2 req dropped: `same_address_o`=0.
- Request exit (mode 0) while busy, with a second `cfg_req_i` pulse in DRAIN:
  - the second pulse is ignored, and exactly one ack is produced;
  - `lockstep_mode_o`=0 after SWITCH.
- `rst_ni` asserted in DRAIN with counters non-zero: all outputs and counters at reset values asynchronously, with no ack.

Source files
------------

// File: rtl/lockstep_mode_ctrl.sv
// lockstep_mode_ctrl: drains outstanding TCDM traffic before switching the lockstep unit's mode,
// and flags same-address broadcasts while lockstep is active.
module lockstep_mode_ctrl #(
    parameter int NB_CORES        = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int DRAIN_TIMEOUT   = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           cfg_req_i,
    input  logic                           cfg_mode_i,
    output logic                           cfg_ack_o,
    output logic                           cfg_err_o,
    output logic                           busy_o,
    input  logic [NB_CORES-1:0]            core_req_i,
    input  logic [NB_CORES-1:0]            core_gnt_i,
    input  logic [NB_CORES-1:0]            core_rvalid_i,
    input  logic [NB_CORES*ADDR_WIDTH-1:0] core_addr_i,
    output logic [NB_CORES-1:0]            core_stall_o,
    output logic                           lockstep_mode_o,
    output logic                           same_address_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [15:0] TIMER_LAST = 16'(DRAIN_TIMEOUT - 1);
    localparam logic TIMEOUT_EN = DRAIN_TIMEOUT != 0;

    typedef enum logic [1:0] {RUN, DRAIN, SWITCH, ABORT} state_t;
    state_t state, state_next;
    logic [NB_CORES-1:0] handshake, cnt_nz, addr_eq;
    logic [15:0] timer;
    logic target, drained, stall;

    assign handshake = core_req_i & core_gnt_i;

    for (genvar k = 0; k < NB_CORES; k++) begin : g_core
        logic [CW-1:0] cnt;
        // a simultaneous grant and response leave the count unchanged
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) cnt <= '0;
            else if (handshake[k] && !core_rvalid_i[k] && cnt != CNT_MAX) cnt <= cnt + 1'b1;
            else if (core_rvalid_i[k] && !handshake[k] && cnt != '0) cnt <= cnt - 1'b1;
        end
        assign cnt_nz[k]  = |cnt;
        assign addr_eq[k] = core_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == core_addr_i[0 +: ADDR_WIDTH];
    end

    assign drained = ~|cnt_nz && ~|handshake;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= RUN;
            timer           <= '0;
            target          <= 1'b0;
            lockstep_mode_o <= 1'b0;
        end else begin
            state <= state_next;
            timer <= (state == DRAIN) ? timer + 1'b1 : '0;
            if (state == RUN && cfg_req_i) target <= cfg_mode_i;
            if (state == DRAIN && drained) lockstep_mode_o <= target;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (cfg_req_i) state_next = (cfg_mode_i != lockstep_mode_o) ? DRAIN : SWITCH;
            DRAIN:   state_next = drained ? SWITCH :
                                  (TIMEOUT_EN && timer == TIMER_LAST) ? ABORT : DRAIN;
            default: state_next = RUN;
        endcase
    end

    assign stall          = state != RUN;
    assign busy_o         = stall;
    assign core_stall_o   = {NB_CORES{stall}};
    assign cfg_ack_o      = state == SWITCH || state == ABORT;
    assign cfg_err_o      = state == ABORT;
    assign same_address_o = lockstep_mode_o && &core_req_i && &addr_eq && !stall;
endmodule

// File: tb/tb_lockstep_mode_ctrl.sv
// tb_lockstep_mode_ctrl: directed and random traffic against a transaction-level model;
// expected acks are queued and matched whenever the DUT pulses cfg_ack_o.
module tb_lockstep_mode_ctrl;
    localparam int N = 8, AW = 32, MO = 4, T = 16, BIG = 1 << 30;

    logic clk_i = 0, rst_ni = 0;
    logic cfg_req_i = 0, cfg_mode_i = 0;
    logic cfg_ack_o, cfg_err_o, busy_o, lockstep_mode_o, same_address_o;
    logic [N-1:0] core_req_i = '0, core_gnt_i = '0, core_rvalid_i = '0, core_stall_o;
    logic [N*AW-1:0] core_addr_i = '0;

    int total = 0, bad = 0;

    lockstep_mode_ctrl #(.NB_CORES(N), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO), .DRAIN_TIMEOUT(T)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_req_i(cfg_req_i), .cfg_mode_i(cfg_mode_i),
        .cfg_ack_o(cfg_ack_o), .cfg_err_o(cfg_err_o), .busy_o(busy_o),
        .core_req_i(core_req_i), .core_gnt_i(core_gnt_i), .core_rvalid_i(core_rvalid_i),
        .core_addr_i(core_addr_i), .core_stall_o(core_stall_o),
        .lockstep_mode_o(lockstep_mode_o), .same_address_o(same_address_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { int cyc; bit err; bit mode; } exp_t;
    exp_t sb[$];
    exp_t e, got;
    int outst[N];
    int sum, cyc = 0, m_start = 0, stall_from = 0, free_at = 0;
    bit m_mode = 0, m_tgt = 0, m_drain = 0, exp_stall, all_eq;
    logic [N-1:0] hs;

    // A request ends one cycle later with an ack; the controller accepts again the cycle after.
    task automatic finish_req(input bit err);
        e.cyc = cyc + 1; e.err = err; e.mode = m_mode;
        sb.push_back(e);
        m_drain = 0;
        free_at = cyc + 2;
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            foreach (outst[k]) outst[k] = 0;
            m_mode = 0; m_drain = 0; stall_from = 0; free_at = 0;
            sb.delete();
        end else begin
            hs = core_req_i & core_gnt_i;
            sum = 0;
            foreach (outst[k]) sum += outst[k];
            if (m_drain) begin
                if (sum == 0 && hs == 0) begin
                    m_mode = m_tgt;
                    finish_req(0);
                end else if (cyc - m_start == T - 1) finish_req(1);
            end else if (cyc >= free_at && cfg_req_i) begin
                stall_from = cyc + 1;
                if (cfg_mode_i == m_mode) finish_req(0);
                else begin
                    m_drain = 1; m_tgt = cfg_mode_i; m_start = cyc + 1; free_at = BIG;
                end
            end
            foreach (outst[k]) begin
                if (hs[k] && !core_rvalid_i[k]) outst[k] = (outst[k] < MO) ? outst[k] + 1 : MO;
                if (core_rvalid_i[k] && !hs[k]) outst[k] = (outst[k] > 0) ? outst[k] - 1 : 0;
            end
            cyc++;
        end
    end

    always @(negedge clk_i) if (rst_ni) begin
        exp_stall = cyc >= stall_from && cyc < free_at;
        all_eq = 1;
        for (int k = 1; k < N; k++)
            if (core_addr_i[k*AW +: AW] != core_addr_i[0 +: AW]) all_eq = 0;
        chk("stall", core_stall_o, {N{exp_stall}});
        chk("busy", busy_o, exp_stall);
        chk("mode", lockstep_mode_o, m_mode);
        chk("same_address", same_address_o, m_mode && &core_req_i && all_eq && !exp_stall);
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("ack_due_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (cfg_ack_o) begin
            chk("ack_expected", cfg_ack_o, sb.size() != 0);
            if (sb.size() != 0) begin
                got = sb.pop_front();
                chk("ack_cycle", cyc, got.cyc);
                chk("ack_err", cfg_err_o, got.err);
                chk("ack_mode", lockstep_mode_o, got.mode);
            end
        end else chk("err_without_ack", cfg_err_o, 0);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic req(input bit m);
        cfg_req_i = 1; cfg_mode_i = m;
        tick();
        cfg_req_i = 0;
    endtask

    task automatic traffic(input logic [N-1:0] hsk, input logic [N-1:0] rv, input int n);
        core_req_i = hsk; core_gnt_i = hsk; core_rvalid_i = rv;
        tick(n);
        core_req_i = '0; core_gnt_i = '0; core_rvalid_i = '0;
    endtask

    initial begin
        tick(2);
        rst_ni = 1;
        tick(2);
        req(1); tick(4);
        req(0); tick(4);
        traffic(8'h21, 8'h00, 2);
        req(1); tick(3);
        traffic(8'h00, 8'h21, 1); tick(2);
        traffic(8'h00, 8'h21, 1); tick(4);
        req(0); tick(4);
        traffic(8'h08, 8'h00, 1);
        req(1); tick(20);
        traffic(8'h00, 8'h08, 1);
        req(1); tick(4);
        core_req_i = '1;
        for (int k = 0; k < N; k++) core_addr_i[k*AW +: AW] = 32'h1000_0040;
        tick(2);
        core_addr_i[7*AW +: AW] = 32'h1000_0044; tick(2);
        core_addr_i[7*AW +: AW] = 32'h1000_0040; tick(2);
        core_req_i[2] = 0; tick(2);
        core_req_i = '0;
        req(1); tick(3);
        traffic(8'h02, 8'h00, 1);
        req(0); tick(2);
        req(1); tick(2);
        traffic(8'h00, 8'h02, 1); tick(5);
        traffic(8'h10, 8'h00, 6);
        traffic(8'h00, 8'h10, 4);
        req(1); tick(5);
        traffic(8'h40, 8'h00, 1);
        req(0); tick(2);
        rst_ni = 0;
        #1;
        chk("rst_stall", core_stall_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_mode", lockstep_mode_o, 0);
        chk("rst_ack", cfg_ack_o, 0);
        chk("rst_err", cfg_err_o, 0);
        chk("rst_same_address", same_address_o, 0);
        #1 rst_ni = 1;
        tick();
        req(1); tick(4);
        for (int i = 0; i < 2000; i++) begin
            core_req_i    = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
            core_gnt_i    = N'($urandom);
            core_rvalid_i = N'($urandom) & N'($urandom);
            cfg_req_i     = $urandom_range(0, 11) == 0;
            cfg_mode_i    = 1'($urandom);
            if ($urandom_range(0, 2) == 0)
                for (int k = 0; k < N; k++) core_addr_i[k*AW +: AW] = 32'h1000_0040;
            else
                for (int k = 0; k < N; k++) core_addr_i[k*AW +: AW] = $urandom_range(0, 1) ? 32'h1000_0040 : $urandom;
            tick();
        end
        core_req_i = '0; core_gnt_i = '0; core_rvalid_i = '0; cfg_req_i = 0;
        tick(T + 10);
        chk("pending_acks", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
